// File: rtl/conv_operand_server.sv
// conv_operand_server
//   Operand memory responder for the convolution engine. Holds one IMG_H x IMG_W
//   byte feature map and one K_DIM x K_DIM byte kernel loaded by the host, and
//   answers the engine's pipelined read requests with a fixed latency.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_load_start        pulse: enter LOAD (from IDLE, or from SERVE via DRAIN)
//   i_load_done         pulse: LOAD -> SERVE
//   i_wr_en/sel/addr/data  host write port (0 = feature map, 1 = kernel)
//   i_rd_req/sel/addr   engine read request
//   o_rd_ready          high only in SERVE
//   o_rd_valid/data/err response, two edges after the accepting edge
//   o_wr_err            one-cycle pulse for a dropped write
//   o_state             00 IDLE, 01 LOAD, 10 DRAIN, 11 SERVE
module conv_operand_server #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned K_DIM = 4,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_start,
  input  logic          i_load_done,
  input  logic          i_wr_en,
  input  logic          i_wr_sel,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_req,
  input  logic          i_rd_sel,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_ready,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_err,
  output logic          o_wr_err,
  output logic [1:0]    o_state
);

  localparam int unsigned MapDepth = IMG_W * IMG_H;
  localparam int unsigned KerDepth = K_DIM * K_DIM;
  localparam int unsigned MapIw    = (MapDepth > 1) ? $clog2(MapDepth) : 1;
  localparam int unsigned KerIw    = (KerDepth > 1) ? $clog2(KerDepth) : 1;
  localparam logic [AW:0] MapLimit = (AW+1)'(MapDepth);
  localparam logic [AW:0] KerLimit = (AW+1)'(KerDepth);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StDrain = 2'b10,
    StServe = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] map_mem [MapDepth];
  logic [DW-1:0] ker_mem [KerDepth];

  // Stage 0: accepted request; stage 1: memory data; stage 2: output registers.
  logic          s0_valid_q, s0_sel_q, s0_err_q;
  logic [AW-1:0] s0_addr_q;
  logic          s1_valid_q, s1_err_q;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          rd_valid_q, rd_err_q;
  logic [DW-1:0] rd_data_q;
  logic          wr_err_q;

  logic accept, rd_oor, wr_oor, wr_ok, pipe_busy;

  function automatic logic out_of_range(input logic sel, input logic [AW-1:0] addr);
    return sel ? ({1'b0, addr} >= KerLimit) : ({1'b0, addr} >= MapLimit);
  endfunction

  assign o_rd_ready = (state_q == StServe);
  assign accept     = i_rd_req & o_rd_ready;
  assign rd_oor     = out_of_range(i_rd_sel, i_rd_addr);
  assign wr_oor     = out_of_range(i_wr_sel, i_wr_addr);
  assign wr_ok      = i_wr_en & (state_q == StLoad) & ~wr_oor;
  // The output register is not counted: its response is already on the pins.
  assign pipe_busy  = s0_valid_q | s1_valid_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_load_start) state_d = StLoad;
      StLoad:  if (i_load_done)  state_d = StServe;
      StServe: if (i_load_start) state_d = (accept | pipe_busy) ? StDrain : StLoad;
      StDrain: if (!pipe_busy)   state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Memories are never reset; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      if (i_wr_sel) ker_mem[i_wr_addr[KerIw-1:0]] <= i_wr_data;
      else          map_mem[i_wr_addr[MapIw-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    s1_data_d = '0;
    if (s0_valid_q && !s0_err_q) begin
      s1_data_d = s0_sel_q ? ker_mem[s0_addr_q[KerIw-1:0]] : map_mem[s0_addr_q[MapIw-1:0]];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      s0_valid_q <= 1'b0;
      s0_sel_q   <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s0_valid_q <= accept;
      s0_sel_q   <= i_rd_sel;
      s0_err_q   <= accept & rd_oor;
      s0_addr_q  <= i_rd_addr;
      s1_valid_q <= s0_valid_q;
      s1_err_q   <= s0_valid_q & s0_err_q;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= s1_valid_q;
      rd_err_q   <= s1_valid_q & s1_err_q;
      rd_data_q  <= s1_valid_q ? s1_data_q : '0;
      wr_err_q   <= i_wr_en & ~wr_ok;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_err   = rd_err_q;
  assign o_rd_data  = rd_data_q;
  assign o_wr_err   = wr_err_q;
  assign o_state    = state_q;

endmodule
